// File: rtl/sumador_pkg.sv
// Shared types and constants for the serial add/subtract unit.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DEF_CHUNK = 4;

endpackage

// File: rtl/sumador_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module sumador_chunk
  import sumador_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  localparam int unsigned CW = CHUNK + 1;

  assign {cout, s} = CW'(a) + CW'(b) + CW'(cin);

endmodule

// File: rtl/sumador_serial_param.sv
// Multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
// Optional saturation on signed overflow when SUMADOR_SAT_EN is defined (adds input sat).
module sumador_serial_param
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             op,
`ifdef SUMADOR_SAT_EN
  input  logic             sat,
`endif
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   resultado,
  output logic             overflow
);

  localparam int unsigned      N          = WIDTH / CHUNK;
  localparam int unsigned      CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SUMADOR_SAT_EN
  logic               sat_q, sat_d;
`endif

  logic               rise_c;
  logic [31:0]        off_c;
  logic [CHUNK-1:0]   a_chunk_c, b_chunk_c, s_c;
  logic               cout_c;

  assign rise_c    = start & ~start_q;
  assign off_c     = 32'(cnt_q) * CHUNK;
  assign a_chunk_c = CHUNK'(a_q >> off_c);
  assign b_chunk_c = CHUNK'(b_q >> off_c);

  sumador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_chunk_c),
    .b    (b_chunk_c),
    .cin  (carry_q),
    .s    (s_c),
    .cout (cout_c)
  );

  // State and datapath registers; reset arms start_q so a held button cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUMADOR_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUMADOR_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    start_d = start;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
`ifdef SUMADOR_SAT_EN
    sat_d   = sat_q;
`endif

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          a_d     = num1;
          b_d     = (op == OP_ADD) ? num2 : ~num2;
          op_d    = op;
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
`ifdef SUMADOR_SAT_EN
          sat_d   = sat;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = (sum_q & ~(CHUNK_MASK << off_c)) | (WIDTH'(s_c) << off_c);
        carry_d = cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          res_d   = {(op_q == OP_SUB) ? ~cout_c : cout_c, sum_d};
`ifdef SUMADOR_SAT_EN
          // Clamp toward the sign of A; bit WIDTH mirrors the clamped sign.
          if (sat_q && ovf_d) begin
            res_d = {a_q[WIDTH-1], a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
          end
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign resultado = res_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sumador_serial_param.sv
// Self-checking bench for sumador_serial_param: arithmetic reference model plus directed cases.
module tb_sumador_serial_param;

  localparam int unsigned W    = 12;
  localparam int unsigned C    = 4;
  localparam int unsigned N    = W / C;
  localparam int          SMAX = (1 << (W - 1)) - 1;
  localparam int          SMIN = -(1 << (W - 1));

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         op    = 1'b0;
  logic         start = 1'b0;
  logic         sat   = 1'b0;
  logic [W-1:0] num1  = '0;
  logic [W-1:0] num2  = '0;
  logic         busy, done, overflow;
  logic [W:0]   resultado;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sumador_serial_param #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .num1      (num1),
    .num2      (num2),
    .op        (op),
`ifdef SUMADOR_SAT_EN
    .sat       (sat),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub, input logic sat_en, output logic v);
    int sa, sb, r;
    logic [W:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r   = sa - sb;
      res = {a < b, a - b};
    end else begin
      r   = sa + sb;
      res = {1'b0, a} + {1'b0, b};
    end
    v = (r > SMAX) || (r < SMIN);
    if (sat_en && v) res = (r > SMAX) ? {2'b00, {(W-1){1'b1}}} : {2'b11, {(W-1){1'b0}}};
    return res;
  endfunction

  // Transaction-level model: an accepted request keeps busy for N+1 cycles, done on the last.
  int         rem        = 0;
  logic       prev_start = 1'b1;
  logic       m_busy     = 1'b0;
  logic       m_done     = 1'b0;
  logic       m_ovf      = 1'b0;
  logic       pend_ovf   = 1'b0;
  logic [W:0] m_res      = '0;
  logic [W:0] pend_res   = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      rem = 0; prev_start = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_ovf = 1'b0;
    end else begin
      if (rem > 0) rem--;
      else if (start && !prev_start) begin
        rem      = int'(N) + 1;
        pend_res = ref_op(num1, num2, op, sat, pend_ovf);
      end
      prev_start = start;
      m_busy = (rem > 0);
      m_done = (rem == 1);
      if (rem == 1) begin
        m_res = pend_res;
        m_ovf = pend_ovf;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_res",  32'(resultado), 32'(m_res));
      check("cyc_ovf",  32'(overflow), 32'(m_ovf));
    end
  end

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic o, input logic s, input logic [W:0] eres, input logic eovf);
    int lat;
    bit seen;
    @(posedge clk); #2;
    num1 = a; num2 = b; op = o; sat = s; start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(N + 1));
    check({name, "_res"}, 32'(resultado), 32'(eres));
    check({name, "_ovf"}, 32'(overflow), 32'(eovf));
    check({name, "_model"}, 32'(m_res), 32'(eres));
    @(posedge clk); #1;
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 12'h000;
      1:       return 12'h7FF;
      2:       return 12'h800;
      3:       return 12'hFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int dcount;
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res",  32'(resultado), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    do_op("add_7ff_1",   12'h7FF, 12'h001, 1'b0, 1'b0, 13'h0800, 1'b1);
    do_op("add_fff_fff", 12'hFFF, 12'hFFF, 1'b0, 1'b0, 13'h1FFE, 1'b0);
    do_op("sub_5_7",     12'h005, 12'h007, 1'b1, 1'b0, 13'h1FFE, 1'b0);
    do_op("sub_800_1",   12'h800, 12'h001, 1'b1, 1'b0, 13'h07FF, 1'b1);
`ifdef SUMADOR_SAT_EN
    do_op("sat_add",     12'h7FF, 12'h001, 1'b0, 1'b1, 13'h07FF, 1'b1);
    do_op("sat_sub",     12'h800, 12'h001, 1'b1, 1'b1, 13'h1800, 1'b1);
    do_op("nosat_add",   12'h7FF, 12'h001, 1'b0, 1'b0, 13'h0800, 1'b1);
    do_op("nosat_sub",   12'h800, 12'h001, 1'b1, 1'b0, 13'h07FF, 1'b1);
`endif

    // Held start, operand change while busy, and a second rise during CALC.
    @(posedge clk); #2;
    num1 = 12'h123; num2 = 12'h456; op = 1'b0; sat = 1'b0; start = 1'b1;
    dcount = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      #1;
      if (c == 0)  num1 = 12'hABC;
      if (c == 1)  start = 1'b0;
      if (c == 2)  start = 1'b1;
      if (c == 12) start = 1'b0;
    end
    check("held_done_count", 32'(dcount), 32'd1);
    check("held_res", 32'(resultado), 32'h579);
    check("held_ovf", 32'(overflow), 32'd0);

    // Reset during the second CALC cycle with start held through reset.
    @(posedge clk); #2;
    num1 = 12'h0F0; num2 = 12'h00F; op = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res",  32'(resultado), 32'd0);
    check("abort_ovf",  32'(overflow), 32'd0);
    #1 rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy || done) bad++;
    end
    check("held_through_reset", 32'(bad), 32'd0);
    start = 1'b0;

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      num1 = pick();
      num2 = pick();
      op   = 1'($urandom);
`ifdef SUMADOR_SAT_EN
      sat  = 1'($urandom);
`endif
      if ($urandom_range(0, 2) == 0) start = ~start;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
